mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_div_step.sv | 33 +++
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings and FSM states for the multiply/divide unit
//
// Purpose : constants and types imported by mult_div_unit and its helpers.
// Contents: OP_* operation encodings (op[1] selects divide, op[0] selects
//           unsigned), state_t FSM enumeration.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
//
// Purpose : shifts the next dividend bit into the partial remainder, trial
//           subtracts the divisor and keeps the difference when it does not
//           borrow, shifting the resulting quotient bit into quo.
// Ports   : rem      partial remainder (always < divisor between steps)
//           quo      dividend bits still to be consumed / quotient so far
//           divisor  divisor magnitude
//           rem_next next partial remainder (top bit is always zero)
//           quo_next next quotient/dividend word
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             borrow;

   assign shifted  = {rem, quo[WIDTH-1]};
   assign diff     = {1'b0, shifted} - {2'b00, divisor};
   assign borrow   = diff[WIDTH+1];

   // On a borrow the shifted value is below the divisor, so it fits and is kept.
   assign rem_next = borrow ? shifted : diff[WIDTH:0];
   assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed/unsigned multiply and divide unit
//
// Purpose : radix-2 Booth multiply and restoring divide sharing one
//           accumulator and one iteration counter; result after WIDTH+2 cycles.
// Ports   : clk      rising-edge clock
//           reset    asynchronous active-high reset
//           start    request, sampled only while busy=0
//           op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//           a, b     multiplicand/dividend, multiplier/divisor
//           busy     operation in progress
//           done     one-cycle completion pulse
//           div_zero pulses with done when a divide had b=0
//           hi, lo   product upper/lower half, or remainder/quotient
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2*WIDTH:0] acc;
   logic             booth_q;

   logic             signed_op;
   logic             div_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   mcand;
   logic [WIDTH+1:0] p_ext;
   logic [WIDTH+1:0] m_ext;
   logic [WIDTH+1:0] booth_sum;
   logic [2*WIDTH:0] mul_next;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             mul_fix;
   logic             b_zero;
   logic [WIDTH-1:0] hi_res;
   logic [WIDTH-1:0] lo_res;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start)         state_next = ST_RUN;
         ST_RUN:  if (count == LAST) state_next = ST_FIX;
         ST_FIX:                     state_next = ST_IDLE;
         default:                    state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = 1'b0;
      if (state != ST_IDLE) busy = 1'b1;
   end

   // ---------------- operand decode ----------------
   assign signed_op = ~op_q[0];
   assign div_op    = op_q[1];
   assign a_neg     = signed_op & a_q[WIDTH-1];
   assign b_neg     = signed_op & b_q[WIDTH-1];
   assign a_mag     = a_neg ? -a_q : a_q;
   assign b_mag     = b_neg ? -b_q : b_q;
   assign b_zero    = (b_q == '0);

   // One-bit extension: sign for MULT, zero for MULTU.
   assign mcand = {a_neg, a_q};

   // ---------------- Booth step ----------------
   // acc = {P[WIDTH:0], Q[WIDTH-1:0]}; booth_q is the multiplier bit shifted
   // out last. The sum is formed one bit wider than P so that subtracting a
   // zero-extended multiplicand cannot overflow before the arithmetic shift.
   assign p_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH]};
   assign m_ext = {mcand[WIDTH], mcand};

   always_comb begin
      booth_sum = p_ext;
      case ({acc[0], booth_q})
         2'b01:   booth_sum = p_ext + m_ext;
         2'b10:   booth_sum = p_ext - m_ext;
         default: booth_sum = p_ext;
      endcase
   end

   assign mul_next = {booth_sum, acc[WIDTH-1:1]};

   // ---------------- restoring divide step ----------------
   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (acc[2*WIDTH-1:WIDTH]),
      .quo      (acc[WIDTH-1:0]),
      .divisor  (b_mag),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // ---------------- result fix-up ----------------
   // The WIDTH Booth steps treat the multiplier as signed. For MULTU the
   // zero-extension bit adds one more Booth step, which reduces to adding the
   // multiplicand into the high half when the multiplier's top bit is set.
   assign mul_fix = (op_q == OP_MULTU) && b_q[WIDTH-1];

   always_comb begin
      hi_res = acc[2*WIDTH-1:WIDTH] + (mul_fix ? a_q : '0);
      lo_res = acc[WIDTH-1:0];
      if (div_op) begin
         if (b_zero) begin
            hi_res = a_q;
            lo_res = '1;
         end else begin
            hi_res = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_res = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         end
      end
   end

   // ---------------- datapath ----------------
   // The first RUN cycle (count=0) loads the accumulator from the captured
   // operands; counts 1..WIDTH each perform one iteration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         booth_q  <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  count <= '0;
               end
            end
            ST_RUN: begin
               if (count == '0) begin
                  acc     <= div_op ? {{(WIDTH+1){1'b0}}, a_mag}
                                    : {{(WIDTH+1){1'b0}}, b_q};
                  booth_q <= 1'b0;
               end else if (div_op) begin
                  acc     <= {rem_next, quo_next};
                  booth_q <= 1'b0;
               end else begin
                  acc     <= mul_next;
                  booth_q <= acc[0];
               end
               count <= count + CW'(1);
            end
            ST_FIX: begin
               hi       <= hi_res;
               lo       <= lo_res;
               done     <= 1'b1;
               div_zero <= div_op & b_zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (WIDTH=32)
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  o;
      logic [31:0] x, y, eh, el;
      logic        edz;
   } vec_t;

   // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, q, r;
      logic [63:0] ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      p  = 64'd0;
      case (o)
         2'b00: p = sx * sy;
         2'b01: p = ux * uy;
         2'b10: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else        p = {32'(x % y), 32'(x / y)};
         end
      endcase
      return p;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         4:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // Issues one request, scrambles the inputs after the accept edge and waits
   // (bounded) for done. lat is the number of edges from accept to done.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz, output logic dn_after);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = -1; rh = '0; rl = '0; rdz = 1'b0; dn_after = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = c; rh = hi; rl = lo; rdz = div_zero;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk); #1;
         dn_after = done;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero", busy, done, div_zero, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      vec_t        v[$];
      int          lat;
      logic [31:0] rh, rl;
      logic        rdz, dn2;
      v.push_back('{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
      v.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
      v.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0});
      v.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
      v.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
      v.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
      v.push_back('{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
      v.push_back('{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
      v.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0});
      v.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
      foreach (v[i]) begin
         run_op(v[i].o, v[i].x, v[i].y, lat, rh, rl, rdz, dn2);
         checks++;
         if (lat !== 34) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d expected 34", i, lat);
         end
         checks++;
         if ({rh, rl} !== {v[i].eh, v[i].el}) begin
            errors++;
            $display("FAIL directed_result[%0d]: got hi=%h lo=%h expected hi=%h lo=%h", i, rh, rl, v[i].eh, v[i].el);
         end
         checks++;
         if (rdz !== v[i].edz) begin
            errors++;
            $display("FAIL directed_div_zero[%0d]: got %b expected %b", i, rdz, v[i].edz);
         end
         checks++;
         if (dn2 !== 1'b0) begin
            errors++;
            $display("FAIL directed_done_pulse[%0d]: done still %b one cycle later, expected 0", i, dn2);
         end
      end
   endtask

   task automatic test_random();
      int          lat;
      logic [31:0] rh, rl, x, y;
      logic [1:0]  o;
      logic [63:0] exp_r;
      logic        rdz, dn2;
      for (int n = 0; n < 60; n++) begin
         o = 2'($urandom_range(0, 3));
         x = pick();
         y = pick();
         exp_r = ref_result(o, x, y);
         run_op(o, x, y, lat, rh, rl, rdz, dn2);
         checks++;
         if (lat !== 34 || {rh, rl} !== exp_r || rdz !== (o[1] && y == 0)) begin
            errors++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dz=%b expected lat=34 hi=%h lo=%h dz=%b",
                     n, o, x, y, lat, rh, rl, rdz, exp_r[63:32], exp_r[31:0], (o[1] && y == 0));
         end
      end
   endtask

   task automatic test_hold();
      int          lat;
      logic [31:0] rh, rl;
      logic        rdz, dn2, stray;
      run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, lat, rh, rl, rdz, dn2);
      stray = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         op = 2'($urandom); a = $urandom; b = $urandom;
         if (done) stray = 1'b1;
      end
      checks++;
      if ({hi, lo} !== 64'h1234_5678 * 64'h9ABC_DEF0 || stray !== 1'b0) begin
         errors++;
         $display("FAIL hold: got hi=%h lo=%h stray_done=%b expected %h and no done", hi, lo, stray,
                  64'h1234_5678 * 64'h9ABC_DEF0);
      end
   endtask

   task automatic test_ignore_start();
      int          dones, lat;
      logic [31:0] rh, rl;
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'hFFFF_FF9C; b = 32'h0000_0007;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0; lat = -1; rh = '0; rl = '0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (lat < 0) begin lat = c; rh = hi; rl = lo; end
         end
         // Stray requests sampled on edges +5 and +20 of the run.
         if (c == 4 || c == 19) begin
            start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
      end
      checks++;
      if (dones !== 1 || lat !== 34) begin
         errors++;
         $display("FAIL ignore_start_count: got %0d dones at lat %0d expected 1 done at 34", dones, lat);
      end
      checks++;
      if ({rh, rl} !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
         errors++;
         $display("FAIL ignore_start_result: got hi=%h lo=%h expected hi=fffffffe lo=fffffff2", rh, rl);
      end
   endtask

   task automatic test_back_to_back();
      int          lat1, lat2;
      logic        busy_after;
      logic [31:0] rh, rl;
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3000;
      @(posedge clk); #1;
      start = 1'b0;
      lat1 = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (done) begin lat1 = c; break; end
      end
      // Second request presented during the done cycle.
      start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      busy_after = busy;
      lat2 = -1; rh = '0; rl = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (done) begin lat2 = c; rh = hi; rl = lo; break; end
      end
      checks++;
      if (lat1 !== 34 || busy_after !== 1'b1 || lat2 !== 34) begin
         errors++;
         $display("FAIL back_to_back_timing: got lat1=%0d busy=%b lat2=%0d expected 34/1/34", lat1, busy_after, lat2);
      end
      checks++;
      if ({rh, rl} !== {32'd6, 32'd142}) begin
         errors++;
         $display("FAIL back_to_back_result: got hi=%h lo=%h expected hi=6 lo=142", rh, rl);
      end
   endtask

   task automatic test_reset_mid();
      int          dones, lat;
      logic [31:0] rh, rl;
      logic        rdz, dn2;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd678;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero", busy, done, div_zero, hi, lo);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
      end
      run_op(2'b00, 32'd6, 32'd7, lat, rh, rl, rdz, dn2);
      checks++;
      if (lat !== 34 || {rh, rl} !== {32'h0, 32'h0000_002A}) begin
         errors++;
         $display("FAIL reset_mid_next_op: got lat=%0d hi=%h lo=%h expected lat=34 hi=0 lo=0000002a", lat, rh, rl);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
